// File: rtl/hdq_pkg.sv
// Shared types and constants for the HDQ poll scheduler.
//   state_e        : scheduler FSM states
//   owner_e        : who owns the in-flight HDQ transaction
//   HDQ_READ_MASK  : clears the HDQ write bit on host-supplied addresses
//   RECOVER_CYCLES : width of the hdq_rst pulse after a timeout
package hdq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_RELEASE,
    ST_RECOVER
  } state_e;

  typedef enum logic {
    OWN_POLL = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  localparam logic [7:0]  HDQ_READ_MASK  = 8'h7F;
  localparam int unsigned RECOVER_CYCLES = 4;

  // Saturating 8-bit increment for event counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/hdq_poll_timer.sv
// Poll period counter and sweep-pending flag.
//   clk, rst    : clock, async active-high reset
//   sweep_done  : 1-cycle pulse when the last register of a sweep completes
//   sweep_pend  : a poll sweep is requested or in progress
module hdq_poll_timer
  import hdq_pkg::*;
#(
  parameter int unsigned POLL_PERIOD = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic sweep_done,
  output logic sweep_pend
);

  localparam int unsigned CNT_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = (cnt == CNT_W'(POLL_PERIOD - 1));

  // Free-running counter; a wrap during an active sweep is dropped, not queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      sweep_pend <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
      if (sweep_pend) begin
        if (sweep_done) sweep_pend <= 1'b0;
      end else if (wrap) begin
        sweep_pend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hdq_poll_scheduler.sv
// Sequences the HDQ master: periodic register sweeps into a shadow file,
// on-demand host reads (host wins at transaction boundaries), and timeout
// recovery with a 4-cycle hdq_rst pulse.
// Optional feature macro: HDQ_POLL_RETRY_EN -- reissue a timed-out address
// once before reporting an error.
// Ports:
//   clk, rst                  : clock, async active-high reset
//   enable                    : periodic polling on
//   host_req/host_addr        : host read request (held until host_ack)
//   host_ack/host_data/host_err : host read completion
//   hdq_start/hdq_addr/hdq_done/hdq_data/hdq_rst : hdq_interface handshake
//   reg_data/reg_valid        : shadow register file
//   err_count                 : saturating timeout count
module hdq_poll_scheduler
  import hdq_pkg::*;
#(
  parameter int unsigned           NUM_REGS    = 4,
  parameter logic [8*NUM_REGS-1:0] REG_ADDRS   = {8'h2F, 8'h0C, 8'h08, 8'h06},
  parameter int unsigned           POLL_PERIOD = 1_000_000,
  parameter int unsigned           TIMEOUT     = 200_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  host_req,
  input  logic [7:0]            host_addr,
  output logic                  host_ack,
  output logic [7:0]            host_data,
  output logic                  host_err,
  output logic                  hdq_start,
  output logic [7:0]            hdq_addr,
  input  logic                  hdq_done,
  input  logic [7:0]            hdq_data,
  output logic                  hdq_rst,
  output logic [8*NUM_REGS-1:0] reg_data,
  output logic [NUM_REGS-1:0]   reg_valid,
  output logic [7:0]            err_count
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam int unsigned RC_W  = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  state_e           state, next_state;
  owner_e           owner;
  logic [IDX_W-1:0] idx;
  logic [TMR_W-1:0] tmr;
  logic [RC_W-1:0]  rcnt;
  logic [7:0]       rdata;
  logic             sweep_pend, sweep_done;
  logic             tmr_exp, rec_last, idx_last, retry_go;
  logic             start_d, rst_d, take_req, take_poll, tmo, done_ok, done_err;

  assign tmr_exp  = (tmr == TMR_W'(TIMEOUT - 1));
  assign rec_last = (rcnt == RC_W'(RECOVER_CYCLES - 1));
  assign idx_last = (idx == IDX_W'(NUM_REGS - 1));

`ifdef HDQ_POLL_RETRY_EN
  logic retried;
  assign retry_go = !retried;
`else
  assign retry_go = 1'b0;
`endif

  assign sweep_done = (done_ok || done_err) && (owner == OWN_POLL) && idx_last;

  hdq_poll_timer #(
    .POLL_PERIOD (POLL_PERIOD)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .sweep_done (sweep_done),
    .sweep_pend (sweep_pend)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; host request has priority over a pending sweep.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:      if (host_req || (sweep_pend && enable)) next_state = ST_ISSUE;
      ST_ISSUE:     next_state = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (hdq_done)     next_state = ST_RELEASE;
        else if (tmr_exp) next_state = ST_RECOVER;
      end
      ST_RELEASE:   if (!hdq_done) next_state = ST_IDLE;
      ST_RECOVER:   if (rec_last) next_state = retry_go ? ST_ISSUE : ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  // Output/strobe decode; start_d and rst_d feed the registered HDQ controls.
  always_comb begin
    start_d   = 1'b0;
    rst_d     = 1'b0;
    take_req  = 1'b0;
    take_poll = 1'b0;
    tmo       = 1'b0;
    done_ok   = 1'b0;
    done_err  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (host_req)                  take_req  = 1'b1;
        else if (sweep_pend && enable) take_poll = 1'b1;
      end
      ST_ISSUE:     start_d = 1'b1;
      ST_WAIT_DONE: begin
        if (!hdq_done) begin
          if (tmr_exp) begin
            tmo   = 1'b1;
            rst_d = 1'b1;
          end else begin
            start_d = 1'b1;
          end
        end
      end
      ST_RELEASE:   done_ok = !hdq_done;
      ST_RECOVER: begin
        rst_d    = !rec_last;
        done_err = rec_last && !retry_go;
      end
      default: ;
    endcase
  end

  // Datapath: address latch, timers, capture, completion and shadow file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_ack  <= 1'b0;
      host_data <= '0;
      host_err  <= 1'b0;
      hdq_start <= 1'b0;
      hdq_addr  <= '0;
      hdq_rst   <= 1'b0;
      reg_data  <= '0;
      reg_valid <= '0;
      err_count <= '0;
      owner     <= OWN_POLL;
      idx       <= '0;
      tmr       <= '0;
      rcnt      <= '0;
      rdata     <= '0;
`ifdef HDQ_POLL_RETRY_EN
      retried   <= 1'b0;
`endif
    end else begin
      host_ack  <= 1'b0;
      hdq_start <= start_d;
      hdq_rst   <= rst_d;

      if (take_req) begin
        hdq_addr <= host_addr & HDQ_READ_MASK;
        owner    <= OWN_HOST;
      end else if (take_poll) begin
        hdq_addr <= REG_ADDRS[{idx, 3'b000} +: 8];
        owner    <= OWN_POLL;
      end

`ifdef HDQ_POLL_RETRY_EN
      if (take_req || take_poll)            retried <= 1'b0;
      else if (state == ST_RECOVER && rec_last) retried <= 1'b1;
`endif

      if (state == ST_ISSUE)          tmr <= '0;
      else if (state == ST_WAIT_DONE) tmr <= tmr + TMR_W'(1);

      if (state == ST_WAIT_DONE && hdq_done) rdata <= hdq_data;

      if (tmo) begin
        err_count <= sat_inc8(err_count);
        rcnt      <= '0;
      end else if (state == ST_RECOVER) begin
        rcnt <= rcnt + RC_W'(1);
      end

      if (done_ok || done_err) begin
        if (owner == OWN_HOST) begin
          host_ack  <= 1'b1;
          host_data <= done_ok ? rdata : 8'h00;
          host_err  <= done_err;
        end else begin
          if (done_ok) begin
            reg_data[{idx, 3'b000} +: 8] <= rdata;
            reg_valid[idx]               <= 1'b1;
          end
          idx <= idx_last ? '0 : idx + IDX_W'(1);
        end
      end
    end
  end

endmodule
